cpu_exec_controller: RTL and testbench
======================================

Name: cpu_exec_controller

Overview:
- Synchronous execution sequencer for the CPU.
- Replaces gated/derived CPU clocking with a single-clock FSM that issues one-cycle cpu_en step pulses.
- Stalls the CPU on IN/OUT instructions until the operator presses the debounced button, and stops it permanently on HALT.
- Owns the switch-input latch, the held display word, the status LEDs and an executed-step counter.

Parameters:
- DIV, 4, tick period in clock cycles (>=2); one CPU step per tick while running.
- DISP_W, 28, width of CPU display data.
- SW_W, 18, width of switch input.

Ports:
- clock  in  1  system clock, all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- button  in  1  debounced operator button, level, synchronous to clock.
- switches  in  SW_W  raw switch bank.
- op_in  in  1  current instruction is IN; stable while cpu_en low.
- op_out  in  1  current instruction is OUT.
- op_halt  in  1  current instruction is HALT.
- cpu_data  in  DISP_W  CPU output value, valid while op_out=1.
- cpu_en  out  1  one-cycle CPU step enable.
- in_data  out  SW_W  latched switch value fed to CPU for IN.
- display  out  32  word to seven-segment output module.
- led_state  out  4  [0]=WAIT_IN, [1]=WAIT_OUT, [2]=HALT, [3]=heartbeat.
- step_count  out  16  number of cpu_en pulses issued.

Behaviour:
- Reset values (asynchronous, while reset_n=0):
  - state=RUN; cpu_en=0; in_data=0; step_count=0; led_state=0.
  - display=32'h07FFFFFF (blank code).
  - Tick counter=0; button history register=0.
- Tick generator:
  - Counter runs 0..DIV-1 and wraps.
  - tick is an internal one-cycle pulse in the cycle where counter==DIV-1.
  - Counter free-runs in all states.
  - Heartbeat led_state[3] toggles on every tick.
- Button edge: btn_rise = button & ~button_q. A button held through reset produces no edge until it is released and pressed again.
- All outputs are registered. cpu_en is high for exactly one cycle, starting the cycle after the deciding event.
- FSM, RUN:
  - Acts on tick only; otherwise holds.
  - Priority on tick: op_halt, then op_in, then op_out, then normal.
  - op_halt: go to HALT, no cpu_en.
  - op_in: go to WAIT_IN, no cpu_en.
  - op_out: go to WAIT_OUT; display <= {zero-extend to 32, cpu_data} on the same edge; no cpu_en.
  - None set: cpu_en pulse.
  - btn_rise in RUN is ignored.
- FSM, WAIT_IN:
  - On btn_rise: in_data <= switches, cpu_en pulse, go to RUN.
  - in_data is valid in the same cycle cpu_en is high.
  - Ticks are ignored.
- FSM, WAIT_OUT:
  - On btn_rise: cpu_en pulse, go to RUN.
  - display keeps the captured value until the next OUT capture (it is not blanked on resume).
- FSM, HALT: terminal. No cpu_en is issued, button is ignored. Exit only via reset_n.
- Simultaneous events:
  - tick and btn_rise in the same cycle while in a WAIT state: the button is served, the tick is discarded.
  - tick and btn_rise in RUN: the tick is served.
  - The state returns to RUN on the same edge cpu_en rises, so the earliest next step is at the next tick.
- step_count increments on every cpu_en pulse and wraps 0xFFFF->0x0000.
- led_state[2:0] are decoded from the registered state: one-hot in WAIT/HALT states, all zero in RUN.
- Reset mid-WAIT or mid-pulse: outputs return to reset values immediately. No pulse is issued on release.

Optional Feature:
- Macro: SINGLE_STEP_EN.
- When defined:
  - Adds input port step_mode (1 bit).
  - While step_mode=1 in RUN, the decision normally made on tick is made on btn_rise instead, with the same priority and outputs; ticks are ignored.
  - With step_mode=0, behaviour is as without the macro.
- When undefined: the step_mode port is absent and RUN acts on tick only.

Test Plan:
1. Reset; DIV=4; ops all 0; run 40 cycles -> cpu_en pulses every 4 cycles, each 1 cycle wide; step_count=10; display=32'h07FFFFFF.
2. op_in=1 at a tick, switches=18'h2A5A5 -> state WAIT_IN, led_state[0]=1, no cpu_en for 50 cycles; press button -> next cycle cpu_en=1, in_data=18'h2A5A5, led_state[0]=0.
3. op_out=1, cpu_data=28'h0001234 at a tick -> display=32'h00001234, led_state[1]=1; press -> single cpu_en; display stays 32'h00001234 after resume.
4. op_halt=1 and op_in=1 together at a tick -> HALT, led_state[2]=1; button presses and ticks for 100 cycles -> no cpu_en; reset_n pulse -> RUN, step_count=0.
5. In WAIT_IN, btn_rise coincides with tick -> exactly one cpu_en; button held high 20 cycles -> no second pulse; step_count preset to 0xFFFF -> wraps to 0x0000.
6. SINGLE_STEP_EN with step_mode=1 -> no cpu_en on ticks; each button press gives one cpu_en.

Source files
------------

// File: rtl/cpu_exec_controller.sv
// cpu_exec_controller: single-clock step sequencer for the CPU.
// Optional build macro: SINGLE_STEP_EN (adds step_mode for button-driven stepping).
module cpu_exec_controller #(
    parameter int DIV    = 4,
    parameter int DISP_W = 28,
    parameter int SW_W   = 18
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              button,
    input  logic [SW_W-1:0]   switches,
    input  logic              op_in,
    input  logic              op_out,
    input  logic              op_halt,
    input  logic [DISP_W-1:0] cpu_data,
`ifdef SINGLE_STEP_EN
    input  logic              step_mode,
`endif
    output logic              cpu_en,
    output logic [SW_W-1:0]   in_data,
    output logic [31:0]       display,
    output logic [3:0]        led_state,
    output logic [15:0]       step_count
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TICK_AT = CW'(DIV - 1);
    localparam logic [31:0] BLANK = 32'h07FF_FFFF;

    typedef enum logic [1:0] {
        S_RUN,
        S_WAIT_IN,
        S_WAIT_OUT,
        S_HALT
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic            tick;
    logic            button_q;
    logic            btn_rise;
    logic            run_evt;
    logic            cpu_en_d;
    logic [SW_W-1:0] in_data_d;
    logic [31:0]     display_d;
    logic [2:0]      led_q;
    logic [2:0]      led_d;
    logic            hb_q;
    logic [15:0]     step_cnt_q;

    assign tick     = (cnt_q == TICK_AT);
    assign btn_rise = button & ~button_q;

    // In step mode the RUN decision is taken on a button edge instead of a tick.
`ifdef SINGLE_STEP_EN
    assign run_evt = step_mode ? btn_rise : tick;
`else
    assign run_evt = tick;
`endif

    assign led_state  = {hb_q, led_q};
    assign step_count = step_cnt_q;

    // Free-running tick divider, wraps at DIV-1 regardless of state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Button history for rising-edge detection.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            button_q <= 1'b0;
        end else begin
            button_q <= button;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: halt beats in beats out on a RUN decision.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RUN: begin
                if (run_evt) begin
                    if (op_halt) begin
                        state_d = S_HALT;
                    end else if (op_in) begin
                        state_d = S_WAIT_IN;
                    end else if (op_out) begin
                        state_d = S_WAIT_OUT;
                    end
                end
            end
            S_WAIT_IN: begin
                if (btn_rise) begin
                    state_d = S_RUN;
                end
            end
            S_WAIT_OUT: begin
                if (btn_rise) begin
                    state_d = S_RUN;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
        endcase
    end

    // Output decisions, registered below so every output is a flop.
    always_comb begin
        cpu_en_d  = 1'b0;
        in_data_d = in_data;
        display_d = display;
        unique case (state_q)
            S_RUN: begin
                if (run_evt && !op_halt && !op_in) begin
                    if (op_out) begin
                        display_d = 32'(cpu_data);
                    end else begin
                        cpu_en_d = 1'b1;
                    end
                end
            end
            S_WAIT_IN: begin
                if (btn_rise) begin
                    in_data_d = switches;
                    cpu_en_d  = 1'b1;
                end
            end
            S_WAIT_OUT: begin
                if (btn_rise) begin
                    cpu_en_d = 1'b1;
                end
            end
            S_HALT: begin
                cpu_en_d = 1'b0;
            end
        endcase
    end

    // Status LEDs follow the state being entered, so they match state_q.
    always_comb begin
        led_d = 3'b000;
        unique case (state_d)
            S_RUN:      led_d = 3'b000;
            S_WAIT_IN:  led_d = 3'b001;
            S_WAIT_OUT: led_d = 3'b010;
            S_HALT:     led_d = 3'b100;
        endcase
    end

    // Output registers; the step counter is written every cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cpu_en     <= 1'b0;
            in_data    <= '0;
            display    <= BLANK;
            led_q      <= 3'b000;
            hb_q       <= 1'b0;
            step_cnt_q <= 16'h0000;
        end else begin
            cpu_en     <= cpu_en_d;
            in_data    <= in_data_d;
            display    <= display_d;
            led_q      <= led_d;
            hb_q       <= hb_q ^ tick;
            step_cnt_q <= step_cnt_q + {15'd0, cpu_en_d};
        end
    end

endmodule

// File: tb/tb_cpu_exec_controller.sv
// tb_cpu_exec_controller: directed bench with a step-level reference model.
// Build with +define+SINGLE_STEP_EN to also exercise button stepping.
module tb_cpu_exec_controller;

    localparam int DIV = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        button;
    logic [17:0] switches;
    logic        op_in;
    logic        op_out;
    logic        op_halt;
    logic [27:0] cpu_data;
`ifdef SINGLE_STEP_EN
    logic        step_mode;
`endif
    logic        cpu_en;
    logic [17:0] in_data;
    logic [31:0] display;
    logic [3:0]  led_state;
    logic [15:0] step_count;

    int n_pass = 0;
    int n_tot  = 0;

    // reference model state
    int          m_cyc;
    int          m_mode;
    logic        m_btn;
    logic        m_en;
    logic        m_hb;
    logic [17:0] m_in;
    logic [31:0] m_disp;
    logic [15:0] m_step;

    cpu_exec_controller #(
        .DIV(DIV),
        .DISP_W(28),
        .SW_W(18)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .button(button),
        .switches(switches),
        .op_in(op_in),
        .op_out(op_out),
        .op_halt(op_halt),
        .cpu_data(cpu_data),
`ifdef SINGLE_STEP_EN
        .step_mode(step_mode),
`endif
        .cpu_en(cpu_en),
        .in_data(in_data),
        .display(display),
        .led_state(led_state),
        .step_count(step_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cyc  = 0;
        m_mode = 0;
        m_btn  = 1'b0;
        m_en   = 1'b0;
        m_hb   = 1'b0;
        m_in   = 18'd0;
        m_disp = 32'h07FF_FFFF;
        m_step = 16'd0;
    endtask

    // mode: 0 run, 1 wait-in, 2 wait-out, 3 halted
    task automatic model_step();
        logic tk;
        logic rise;
        logic act;
        tk = ((m_cyc % DIV) == DIV - 1);
        m_cyc++;
        rise = button && !m_btn;
        m_btn = button;
        act = tk;
`ifdef SINGLE_STEP_EN
        if (step_mode) act = rise;
`endif
        m_en = 1'b0;
        case (m_mode)
            0: if (act) begin
                if (op_halt) m_mode = 3;
                else if (op_in) m_mode = 1;
                else if (op_out) begin
                    m_mode = 2;
                    m_disp = {4'h0, cpu_data};
                end else m_en = 1'b1;
            end
            1: if (rise) begin
                m_in = switches;
                m_en = 1'b1;
                m_mode = 0;
            end
            2: if (rise) begin
                m_en = 1'b1;
                m_mode = 0;
            end
            default: ;
        endcase
        if (m_en) m_step++;
        if (tk) m_hb = !m_hb;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (reset_n === 1'b1) begin
                chk("cpu_en", 32'(cpu_en), 32'(m_en));
                chk("in_data", 32'(in_data), 32'(m_in));
                chk("display", display, m_disp);
                chk("step_count", 32'(step_count), 32'(m_step));
                chk("led_state", 32'(led_state),
                    32'({m_hb, m_mode == 3, m_mode == 2, m_mode == 1}));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic cyc(inout int pulses);
        @(posedge clock);
        #1;
        pulses += int'(cpu_en);
    endtask

    initial begin
        int pulses;
        int first;
        reset_n  = 1'b0;
        button   = 1'b0;
        switches = 18'd0;
        op_in    = 1'b0;
        op_out   = 1'b0;
        op_halt  = 1'b0;
        cpu_data = 28'd0;
`ifdef SINGLE_STEP_EN
        step_mode = 1'b0;
`endif
        repeat (2) @(posedge clock);
        #1;
        chk("rst_display", display, 32'h07FF_FFFF);
        chk("rst_step", 32'(step_count), 32'd0);
        chk("rst_led", 32'(led_state), 32'd0);
        chk("rst_cpu_en", 32'(cpu_en), 32'd0);
        reset_n = 1'b1;

        // free run
        pulses = 0;
        repeat (40) cyc(pulses);
        chk("t1_pulses", 32'(pulses), 32'd10);
        chk("t1_step", 32'(step_count), 32'd10);
        chk("t1_display", display, 32'h07FF_FFFF);

        // IN stall
        op_in = 1'b1;
        switches = 18'h2A5A5;
        pulses = 0;
        repeat (54) cyc(pulses);
        chk("t2_nopulse", 32'(pulses), 32'd0);
        chk("t2_led", 32'(led_state[2:0]), 32'd1);
        button = 1'b1;
        op_in = 1'b0;
        @(posedge clock);
        #1;
        chk("t2_cpu_en", 32'(cpu_en), 32'd1);
        chk("t2_in_data", 32'(in_data), 32'h2A5A5);
        chk("t2_led_clr", 32'(led_state[2:0]), 32'd0);
        button = 1'b0;

        // OUT stall
        op_out = 1'b1;
        cpu_data = 28'h0001234;
        pulses = 0;
        repeat (DIV + 1) cyc(pulses);
        chk("t3_display", display, 32'h0000_1234);
        chk("t3_led", 32'(led_state[2:0]), 32'd2);
        op_out = 1'b0;
        cpu_data = 28'hABCDEF0;
        button = 1'b1;
        @(posedge clock);
        #1;
        chk("t3_cpu_en", 32'(cpu_en), 32'd1);
        button = 1'b0;
        repeat (12) @(posedge clock);
        #1;
        chk("t3_display_kept", display, 32'h0000_1234);

        // HALT wins over IN
        op_halt = 1'b1;
        op_in = 1'b1;
        pulses = 0;
        repeat (DIV + 1) cyc(pulses);
        chk("t4_led", 32'(led_state[2:0]), 32'd4);
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            button = ((i % 10) < 5);
            cyc(pulses);
        end
        chk("t4_nopulse", 32'(pulses), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("t4_rst_step", 32'(step_count), 32'd0);
        chk("t4_rst_led", 32'(led_state), 32'd0);
        chk("t4_rst_display", display, 32'h07FF_FFFF);
        op_halt = 1'b0;
        op_in = 1'b0;
        button = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // button edge coincides with tick in WAIT_IN
        op_in = 1'b1;
        switches = 18'h15A5A;
        repeat (7) @(posedge clock);
        #1;
        chk("t5_led", 32'(led_state[2:0]), 32'd1);
        button = 1'b1;
        pulses = 0;
        first = -1;
        for (int i = 1; i <= 20; i++) begin
            cyc(pulses);
            if (pulses == 1 && first < 0) first = i;
        end
        chk("t5_pulses", 32'(pulses), 32'd1);
        chk("t5_first", 32'(first), 32'd1);
        chk("t5_in_data", 32'(in_data), 32'h15A5A);
        chk("t5_rewait", 32'(led_state[2:0]), 32'd1);

        // step counter wrap
        force dut.step_cnt_q = 16'hFFFF;
        m_step = 16'hFFFF;
        @(posedge clock);
        #1;
        release dut.step_cnt_q;
        button = 1'b0;
        @(posedge clock);
        #1;
        button = 1'b1;
        @(posedge clock);
        #1;
        chk("t5_wrap_en", 32'(cpu_en), 32'd1);
        chk("t5_wrap_step", 32'(step_count), 32'd0);
        button = 1'b0;
        op_in = 1'b0;
        repeat (3) @(posedge clock);

`ifdef SINGLE_STEP_EN
        // button-driven stepping
        #1;
        reset_n = 1'b0;
        #1;
        step_mode = 1'b1;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        pulses = 0;
        repeat (20) cyc(pulses);
        chk("t6_noticks", 32'(pulses), 32'd0);
        for (int i = 0; i < 3; i++) begin
            button = 1'b1;
            cyc(pulses);
            button = 1'b0;
            repeat (5) cyc(pulses);
        end
        chk("t6_presses", 32'(pulses), 32'd3);
        chk("t6_step", 32'(step_count), 32'd3);
        step_mode = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
